// File: rtl/pixel_write_queue.sv
// Pixel write queue: three handshaked pixel sources arbitrated by fixed priority
// (erase > screen > draw), clipped to the visible area, buffered in a small FIFO
// and replayed one pixel per cycle towards the VGA adapter.
module pixel_write_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XMAX  = 160,
    parameter int unsigned YMAX  = 120
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    hold,
    input  logic                    erase_valid,
    output logic                    erase_ready,
    input  logic [7:0]              erase_x,
    input  logic [6:0]              erase_y,
    input  logic [2:0]              erase_colour,
    input  logic                    screen_valid,
    output logic                    screen_ready,
    input  logic [7:0]              screen_x,
    input  logic [6:0]              screen_y,
    input  logic [2:0]              screen_colour,
    input  logic                    draw_valid,
    output logic                    draw_ready,
    input  logic [7:0]              draw_x,
    input  logic [6:0]              draw_y,
    input  logic [2:0]              draw_colour,
    output logic                    plot,
    output logic [7:0]              x,
    output logic [6:0]              y,
    output logic [2:0]              colour,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    empty,
    output logic [7:0]              clip_count
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);
    // One extra bit so limits up to 256 / 128 still compare correctly.
    localparam logic [8:0]  XLim      = 9'(XMAX);
    localparam logic [7:0]  YLim      = 8'(YMAX);

    // Entry layout: {x[7:0], y[6:0], colour[2:0]}
    logic [17:0]   mem [DEPTH];

    logic [AW-1:0] headQ, headD, tailQ, tailD;
    logic [AW:0]   levelQ, levelD;
    logic          plotQ, plotD;
    logic [7:0]    xQ, xD;
    logic [6:0]    yQ, yD;
    logic [2:0]    colourQ, colourD;
    logic [7:0]    clipQ, clipD;

    logic          full, xfer, inRange, push, pop, clipHit;
    logic [17:0]   selPix;

    // Readies, arbitration and clipping decision for the current cycle
    always_comb begin
        full         = (levelQ == FullLevel);
        erase_ready  = ~full & ~flush;
        screen_ready = erase_ready & ~erase_valid;
        draw_ready   = screen_ready & ~screen_valid;

        xfer   = 1'b0;
        selPix = '0;
        if (erase_valid && erase_ready) begin
            xfer   = 1'b1;
            selPix = {erase_x, erase_y, erase_colour};
        end else if (screen_valid && screen_ready) begin
            xfer   = 1'b1;
            selPix = {screen_x, screen_y, screen_colour};
        end else if (draw_valid && draw_ready) begin
            xfer   = 1'b1;
            selPix = {draw_x, draw_y, draw_colour};
        end

        inRange = ({1'b0, selPix[17:10]} < XLim) && ({1'b0, selPix[9:3]} < YLim);
        push    = xfer & inRange;
        clipHit = xfer & ~inRange;
        pop     = (levelQ != '0) & ~hold & ~flush;
    end

    // Next-state for pointers, occupancy, output pixel and clip counter
    always_comb begin
        headD   = headQ;
        tailD   = tailQ;
        levelD  = levelQ;
        plotD   = pop;
        xD      = xQ;
        yD      = yQ;
        colourD = colourQ;
        clipD   = clipQ;

        if (clipHit && (clipQ != 8'hFF)) begin
            clipD = clipQ + 8'd1;
        end

        if (flush) begin
            headD  = '0;
            tailD  = '0;
            levelD = '0;
        end else begin
            if (push) begin
                tailD = tailQ + 1'b1;
            end
            if (pop) begin
                headD = headQ + 1'b1;
                {xD, yD, colourD} = mem[headQ];
            end
            if (push && !pop) begin
                levelD = levelQ + 1'b1;
            end else if (pop && !push) begin
                levelD = levelQ - 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            headQ   <= '0;
            tailQ   <= '0;
            levelQ  <= '0;
            plotQ   <= 1'b0;
            xQ      <= '0;
            yQ      <= '0;
            colourQ <= '0;
            clipQ   <= '0;
        end else begin
            headQ   <= headD;
            tailQ   <= tailD;
            levelQ  <= levelD;
            plotQ   <= plotD;
            xQ      <= xD;
            yQ      <= yD;
            colourQ <= colourD;
            clipQ   <= clipD;
        end
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tailQ] <= selPix;
        end
    end

    assign plot       = plotQ;
    assign x          = xQ;
    assign y          = yQ;
    assign colour     = colourQ;
    assign level      = levelQ;
    assign empty      = (levelQ == '0);
    assign clip_count = clipQ;

endmodule
